thermo_led_decoder: RTL and testbench

//  Inverse of the adder LED bar driver: takes a 6-bit thermometer bar (switch bank or

---
 rtl/thermo_led_decoder.sv | 154 +++++++++++++++
 tb/tb_thermo_led_decoder.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/thermo_led_decoder.sv
// thermo_led_decoder: synchronise, debounce and decode a thermometer LED bar
// into a binary count handed downstream on a valid/ready handshake.
//
// Ports:
//   clk, rst_n   system clock (rising edge), async active-low reset
//   therm_in     raw thermometer bar, async to clk (bit0 = lowest LED)
//   out_ready    downstream accept
//   out_valid    out_count holds a new decoded value
//   out_count    number of lit LEDs, 0..WIDTH
//   err_bubble   one-cycle pulse: stable input was not a thermometer code
//
// Optional macro THERMO_BUBBLE_FIX_EN: a bubbled stable code is presented
// as popcount(code) together with the err_bubble pulse instead of dropped.
module thermo_led_decoder #(
    parameter int WIDTH         = 6,
    parameter int OUT_W         = 3,
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] therm_in,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_count,
    output logic             err_bubble
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        PRESENT
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_s_q;
    logic [WIDTH-1:0] r_cand;
    logic [WIDTH-1:0] w_cand_nxt;
    logic [WIDTH-1:0] r_last;
    logic [WIDTH-1:0] w_last_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_valid;
    logic             w_valid_nxt;
    logic [OUT_W-1:0] r_count;
    logic [OUT_W-1:0] w_count_nxt;
    logic             r_err;
    logic             w_err_nxt;

    logic [WIDTH-1:0] w_cand_inc;
    logic             w_legal;
    logic [OUT_W-1:0] w_pop;

    // A legal code is 2^k-1: adding one clears every set bit.
    assign w_cand_inc = r_cand + WIDTH'(1);
    assign w_legal    = ~|(r_cand & w_cand_inc);

    // For a legal code the popcount equals k.
    always_comb begin
        w_pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_pop = w_pop + OUT_W'(r_cand[i]);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cand_nxt  = r_cand;
        w_last_nxt  = r_last;
        w_cnt_nxt   = r_cnt;
        w_valid_nxt = r_valid;
        w_count_nxt = r_count;
        w_err_nxt   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (r_s_q != r_last) begin
                    w_cand_nxt  = r_s_q;
                    w_cnt_nxt   = '0;
                    w_state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                if (r_s_q != r_cand) begin
                    w_cand_nxt = r_s_q;
                    w_cnt_nxt  = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_last_nxt = r_cand;
                    if (r_cand == r_last) begin
                        // Glitch settled back to the reported code.
                        w_state_nxt = IDLE;
                    end else if (w_legal) begin
                        w_count_nxt = w_pop;
                        w_valid_nxt = 1'b1;
                        w_state_nxt = PRESENT;
                    end else begin
`ifdef THERMO_BUBBLE_FIX_EN
                        w_count_nxt = w_pop;
                        w_valid_nxt = 1'b1;
                        w_err_nxt   = 1'b1;
                        w_state_nxt = PRESENT;
`else
                        w_err_nxt   = 1'b1;
                        w_state_nxt = IDLE;
`endif
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            PRESENT: begin
                if (out_ready) begin
                    w_valid_nxt = 1'b0;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_sync1 <= '0;
            r_s_q   <= '0;
            r_cand  <= '0;
            r_last  <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sync1 <= therm_in;
            r_s_q   <= r_sync1;
            r_cand  <= w_cand_nxt;
            r_last  <= w_last_nxt;
            r_cnt   <= w_cnt_nxt;
            r_valid <= w_valid_nxt;
            r_count <= w_count_nxt;
            r_err   <= w_err_nxt;
        end
    end

    assign out_valid  = r_valid;
    assign out_count  = r_count;
    assign err_bubble = r_err;

endmodule

// File: tb/tb_thermo_led_decoder.sv
// tb_thermo_led_decoder: random and directed stimulus, queue scoreboard
// against a segment-level reference model of the bar decoder.
module tb_thermo_led_decoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] therm_in;
    logic       out_ready;
    logic       out_valid;
    logic [2:0] out_count;
    logic       err_bubble;

    thermo_led_decoder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .therm_in   (therm_in),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_count  (out_count),
        .err_bubble (err_bubble)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cnt;
        bit bub;
    } exp_t;

    exp_t       q[$];
    logic [5:0] m_last;
    int         n_checks = 0;
    int         n_pass = 0;
    bit         rmode = 0;

    task automatic check(input bit ok, input string nm,
                         input int act, input int expv);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    endtask

    function automatic bit is_legal(input logic [5:0] v);
        for (int k = 0; k <= 6; k++) begin
            if (int'(v) == (1 << k) - 1) return 1'b1;
        end
        return 1'b0;
    endfunction

    // A value held long enough is reported only if it differs from
    // the last stable code; bubbles report as errors.
    task automatic model_step(input logic [5:0] v);
        exp_t e;
        if (v != m_last) begin
            m_last = v;
            e.cnt  = $countones(v);
            e.bub  = !is_legal(v);
            q.push_back(e);
        end
    endtask

    task automatic hold(input logic [5:0] v, input int n);
        therm_in = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic seg_long(input logic [5:0] v, input int n);
        model_step(v);
        hold(v, n);
    endtask

    // Random ready with a bounded low run.
    initial begin
        int lowrun = 0;
        forever begin
            @(posedge clk);
            #2;
            if (rmode) begin
                if (lowrun >= 3 || $urandom_range(3) != 0) begin
                    out_ready = 1'b1;
                    lowrun = 0;
                end else begin
                    out_ready = 1'b0;
                    lowrun++;
                end
            end
        end
    end

    // Monitor
    initial begin
        exp_t e;
        bit   err_seen = 0;
        bit   prev_hold = 0;
        int   prev_count = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                err_seen  = 0;
                prev_hold = 0;
            end else begin
                if (prev_hold) begin
                    check(out_valid == 1'b1, "hold_valid", out_valid, 1);
                    check(int'(out_count) == prev_count, "hold_count",
                          out_count, prev_count);
                end
                if (err_bubble) begin
`ifdef THERMO_BUBBLE_FIX_EN
                    check(out_valid == 1'b1, "err_with_valid", out_valid, 1);
                    err_seen = 1;
`else
                    check(out_valid == 1'b0, "err_no_valid", out_valid, 0);
                    check(q.size() != 0, "err_expected", q.size(), 1);
                    if (q.size() != 0) begin
                        e = q.pop_front();
                        check(e.bub, "err_is_bubble", 1, int'(e.bub));
                    end
`endif
                end
                if (out_valid && out_ready) begin
                    check(q.size() != 0, "xfer_expected", q.size(), 1);
                    if (q.size() != 0) begin
                        e = q.pop_front();
                        check(int'(out_count) == e.cnt, "xfer_count",
                              out_count, e.cnt);
`ifdef THERMO_BUBBLE_FIX_EN
                        check(err_seen == e.bub, "xfer_bubble_flag",
                              int'(err_seen), int'(e.bub));
`else
                        check(!e.bub, "xfer_not_bubble", 1, int'(e.bub));
`endif
                    end
                    err_seen = 0;
                end
                prev_hold  = out_valid && !out_ready;
                prev_count = out_count;
            end
        end
    end

    initial begin
        int         lat;
        logic [5:0] v;
        rst_n     = 1'b0;
        therm_in  = 6'b000111;
        out_ready = 1'b1;
        m_last    = '0;
        repeat (3) @(posedge clk);
        #1;
        check(out_valid == 1'b0, "rst_valid", out_valid, 0);
        check(out_count == 3'd0, "rst_count", out_count, 0);
        check(err_bubble == 1'b0, "rst_err", err_bubble, 0);

        model_step(6'b000111);
        rst_n = 1'b1;
        lat = 0;
        for (int e = 1; e <= 20 && lat == 0; e++) begin
            @(posedge clk);
            #1;
            if (out_valid) lat = e;
        end
        check(lat == 7, "latency_edges", lat, 7);
        hold(6'b000111, 8);

        for (int k = 0; k <= 6; k++) begin
            v = 6'((1 << k) - 1);
            seg_long(v, 10);
        end
        seg_long(6'b111111, 10);

        seg_long(6'b000011, 12);
        hold(6'b000111, 2);
        seg_long(6'b000011, 12);

        out_ready = 1'b0;
        seg_long(6'b111111, 10);
        seg_long(6'b000001, 10);
        check(out_valid == 1'b1, "bp_valid", out_valid, 1);
        check(out_count == 3'd6, "bp_count", out_count, 6);
        out_ready = 1'b1;
        hold(6'b000001, 20);

        seg_long(6'b000101, 30);

        seg_long(6'b000000, 14);
        out_ready = 1'b0;
        model_step(6'b111111);
        therm_in = 6'b111111;
        for (int i = 0; i < 30 && !out_valid; i++) begin
            @(posedge clk);
            #1;
        end
        check(out_valid == 1'b1, "pre_rst_valid", out_valid, 1);
        #3;
        rst_n = 1'b0;
        #1;
        check(out_valid == 1'b0, "async_rst_valid", out_valid, 0);
        check(out_count == 3'd0, "async_rst_count", out_count, 0);
        q.delete();
        m_last = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        seg_long(6'b111111, 14);

        rmode = 1;
        for (int s = 0; s < 40; s++) begin
            if ($urandom_range(3) == 0) v = 6'($urandom_range(63));
            else v = 6'((1 << $urandom_range(6)) - 1);
            seg_long(v, 14 + int'($urandom_range(8)));
            if ($urandom_range(9) < 3) begin
                hold(6'($urandom_range(63)), 1 + int'($urandom_range(2)));
            end
        end
        hold(therm_in, 20);
        for (int i = 0; i < 200 && q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        check(q.size() == 0, "drain_empty", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
